score_bcd_display: RTL and testbench



---
 rtl/score_disp_pkg.sv | 25 ++
 rtl/score_bcd_display_if.sv | 12 +
 rtl/bin2bcd_dd.sv | 59 +++++
 rtl/score_bcd_display.sv | 64 ++++++
 tb/tb_score_bcd_display.sv | 115 +++++++++++
 5 files changed

// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared types, segment constants and helpers for the score display
package score_disp_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  // ceil(w*1.21/4)*4: BCD register width that never overflows mid-conversion
  function automatic int bcd_width(input int w);
    return ((w * 121 + 399) / 400) * 4;
  endfunction
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/score_bcd_display_if.sv
// score_bcd_display_if: score/ingame from the game block and display/BCD results back
interface score_bcd_display_if #(parameter int SCORE_W = 16, parameter int DIGITS = 5);
  logic [SCORE_W-1:0] score;
  logic ingame;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  logic [4*DIGITS-1:0] bcd;
  logic valid;
  logic overflow;
  modport master(output score, ingame, input seg, an, bcd, valid, overflow);
  modport slave(input score, ingame, output seg, an, bcd, valid, overflow);
endinterface

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: sequential double-dabble converter, one bit per SHIFT cycle
module bin2bcd_dd import score_disp_pkg::*; #(
  parameter int BIN_W = 16,
  parameter int BCD_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  localparam int CW = $clog2(BIN_W + 1);
  conv_state_t state_q, state_d;
  logic [BCD_W+BIN_W-1:0] sh_q, sh_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[BIN_W+4*i +: 4] = sh_q[BIN_W+4*i +: 4] + (sh_q[BIN_W+4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: begin
        sh_d = {{BCD_W{1'b0}}, bin};
        cnt_d = CW'(BIN_W);
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d = adj << 1;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? DONE : SHIFT;
        bcd_d = cnt_q == CW'(1) ? sh_d[BIN_W +: BCD_W] : bcd_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy = state_q != IDLE;
    done = state_q == DONE;
    bcd = bcd_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
    end
endmodule

// File: rtl/score_bcd_display.sv
// score_bcd_display: score-to-BCD conversion and multiplexed common-anode 7-segment drive
module score_bcd_display import score_disp_pkg::*; #(
  parameter int SCORE_W = 16,
  parameter int DIGITS = 5,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic reset,
  score_bcd_display_if.slave bus
);
  localparam int BW0 = bcd_width(SCORE_W);
  localparam int BW = BW0 > 4 * DIGITS ? BW0 : 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [SCORE_W-1:0] score_q, score_d;
  logic valid_q, valid_d, valid, start, busy, done, ovf, blank;
  logic [BW-1:0] res;
  logic [4*DIGITS-1:0] bcd_disp;
  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0] nib;
  bin2bcd_dd #(.BIN_W(SCORE_W), .BCD_W(BW)) u_conv (
    .clk(clk), .reset(reset), .start(start), .bin(score_q),
    .busy(busy), .done(done), .bcd(res)
  );
  always_comb begin
    start = !busy && (!valid_q || bus.score != score_q);
    score_d = start ? bus.score : score_q;
    valid = valid_q | done;
    valid_d = valid;
    ovf = |(res >> (4 * DIGITS));
    bcd_disp = ovf ? {DIGITS{4'h9}} : res[4*DIGITS-1:0];
    ref_d = ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + 1'b1;
    idx_d = ref_q != RW'(REFRESH_DIV - 1) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    nib = 4'(bcd_disp >> {idx_q, 2'b00});
    // a digit is a leading zero when it and every digit above it are zero
    blank = idx_q != '0 && (bcd_disp >> {idx_q, 2'b00}) == '0;
    an_d = ~(DIGITS'(1) << idx_q);
    seg_d = !bus.ingame ? SEG_DASH : (!valid || blank) ? SEG_BLANK : seg_decode(nib);
    bus.seg = seg_q;
    bus.an = an_q;
    bus.bcd = bcd_disp;
    bus.valid = valid;
    bus.overflow = ovf;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      score_q <= '0;
      valid_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q <= '1;
    end else begin
      score_q <= score_d;
      valid_q <= valid_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
endmodule

// File: tb/tb_score_bcd_display.sv
// tb_score_bcd_display: directed checks of conversion latency, clamping, scan and reset
module tb_score_bcd_display;
  logic clk = 1'b0;
  logic reset;
  int n_tests = 0;
  int n_fail = 0;
  score_bcd_display_if #(.SCORE_W(16), .DIGITS(5)) b0();
  score_bcd_display_if #(.SCORE_W(16), .DIGITS(4)) b1();
  score_bcd_display #(.SCORE_W(16), .DIGITS(5), .REFRESH_DIV(4)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  score_bcd_display #(.SCORE_W(16), .DIGITS(4), .REFRESH_DIV(4)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic scan_check(input string tag, input logic [34:0] exp);
    logic [4:0] prev;
    int run, d;
    bit seen;
    prev = b0.an;
    run = 0;
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (b0.an != prev) begin
        if (seen) check({tag, "_dwell"}, run, 4);
        check({tag, "_order"}, b0.an, {prev[3:0], prev[4]});
        seen = 1;
        run = 1;
        prev = b0.an;
      end else run++;
      check({tag, "_onehot"}, $countones(~b0.an), 1);
      d = 0;
      for (int i = 0; i < 5; i++) if (!b0.an[i]) d = i;
      check({tag, "_seg"}, b0.seg, exp[d*7 +: 7]);
    end
  endtask
  initial begin
    reset = 1'b0;
    b0.score = 16'd0;
    b0.ingame = 1'b1;
    b1.score = 16'd65535;
    b1.ingame = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_bcd", b0.bcd, 20'h0);
    check("rst_valid", b0.valid, 0);
    check("rst_ovf", b0.overflow, 0);
    check("rst_seg", b0.seg, 7'h7F);
    check("rst_an", b0.an, 5'h1F);
    @(negedge clk);
    reset = 1'b0;
    repeat (17) @(negedge clk);
    check("lat0_early", b0.valid, 0);
    @(negedge clk);
    check("lat0_valid", b0.valid, 1);
    check("lat0_bcd", b0.bcd, 20'h00000);
    check("lat0_ovf", b0.overflow, 0);
    check("ovf_bcd", b1.bcd, 16'h9999);
    check("ovf_flag", b1.overflow, 1);
    scan_check("zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    b0.score = 16'd1234;
    b1.score = 16'd42;
    repeat (17) @(negedge clk);
    check("s1234_early", b0.bcd, 20'h00000);
    check("s42_ovf_held", b1.overflow, 1);
    @(negedge clk);
    check("s1234_bcd", b0.bcd, 20'h01234);
    check("s42_bcd", b1.bcd, 16'h0042);
    check("s42_ovf", b1.overflow, 0);
    scan_check("s1234", {7'h7F, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    b0.score = 16'd4321;
    repeat (2) @(negedge clk);
    b0.score = 16'd5678;
    repeat (16) @(negedge clk);
    check("mid_first", b0.bcd, 20'h04321);
    repeat (18) @(negedge clk);
    check("mid_hold", b0.bcd, 20'h04321);
    @(negedge clk);
    check("mid_second", b0.bcd, 20'h05678);
    @(negedge clk);
    b0.score = 16'd7;
    b0.ingame = 1'b0;
    repeat (18) @(negedge clk);
    check("idle_bcd", b0.bcd, 20'h00007);
    check("idle_valid", b0.valid, 1);
    scan_check("dash", {5{7'b0111111}});
    b0.ingame = 1'b1;
    b0.score = 16'd99;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_bcd", b0.bcd, 20'h0);
    check("arst_valid", b0.valid, 0);
    check("arst_seg", b0.seg, 7'h7F);
    check("arst_an", b0.an, 5'h1F);
    check("arst_ovf", b0.overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (17) @(negedge clk);
    check("arst_early", b0.valid, 0);
    @(negedge clk);
    check("arst_valid_after", b0.valid, 1);
    check("arst_bcd_after", b0.bcd, 20'h00099);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
